io_config_loader: RTL and testbench

- Serial configuration controller for a column of I/O blocks.
- Each I/O block holds a 3-bit config word: TSMUX[1:0] (output-enable mode) and DORREG (input path select: direct or registered).
- The loader accepts config words from a host over a valid/ready handshake and shifts them MSB-first into the daisy-chained shadow registers.
- After the last word it pulses a latch so every I/O block adopts its new config in the same cycle.

---
 rtl/io_config_loader.sv | 142 ++++++++++++++
 tb/tb_io_config_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_config_loader.sv
`default_nettype none
// ============================================================================
// io_config_loader: streams host config words MSB-first into a daisy chain of
// I/O block shadow registers, then pulses a latch. Revision: 1.0
// ============================================================================
module io_config_loader #(
  parameter int NUM_IOB = 8,
  parameter int CFG_W   = 3
) (
  input  logic             IOCLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic             WVALID,
  output logic             WREADY,
  input  logic [CFG_W-1:0] WDATA,
  output logic             CFG_SDO,
  output logic             CFG_SEN,
  output logic             CFG_LATCH,
  output logic             BUSY,
  output logic             DONE
);

  localparam int WCNT_W = $clog2(NUM_IOB + 1);
  localparam int BCNT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_IOB);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(CFG_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_LATCH  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CFG_W-1:0]    shreg_q, shreg_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WCNT_W-1:0]   word_cnt_inc;

  always_ff @(posedge IOCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    busy_d       = busy_q;
    done_d       = done_q;
    word_cnt_inc = word_cnt_q + WCNT_W'(1);
    WREADY       = 1'b0;
    CFG_SDO      = 1'b0;
    CFG_SEN      = 1'b0;
    CFG_LATCH    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d    = ST_ACCEPT;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          word_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      ST_ACCEPT: begin
        WREADY = 1'b1;
        // Abort wins over a simultaneous transfer; the offered word is dropped.
        if (ABORT) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (WVALID) begin
          shreg_d   = WDATA;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        CFG_SEN = 1'b1;
        CFG_SDO = shreg_q[CFG_W-1];
        if (ABORT) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else begin
          shreg_d = shreg_q << 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_inc;
            state_d    = (word_cnt_inc == LAST_WORD) ? ST_LATCH : ST_ACCEPT;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end
      end

      ST_LATCH: begin
        // Status flips on entry to FINISH so it is visible during that cycle.
        CFG_LATCH = 1'b1;
        state_d   = ST_FINISH;
        busy_d    = 1'b0;
        done_d    = 1'b1;
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_io_config_loader.sv
`default_nettype none
// Directed bench for io_config_loader with a two-block chain and a bench-side
// model of the shadow/active registers fed from the serial outputs.
module tb_io_config_loader;

  localparam int NUM_IOB = 2;
  localparam int CFG_W   = 3;

  logic             IOCLK  = 1'b0;
  logic             RST_N  = 1'b1;
  logic             START  = 1'b0;
  logic             ABORT  = 1'b0;
  logic             WVALID = 1'b0;
  logic [CFG_W-1:0] WDATA  = '0;
  logic             WREADY;
  logic             CFG_SDO;
  logic             CFG_SEN;
  logic             CFG_LATCH;
  logic             BUSY;
  logic             DONE;

  int checks   = 0;
  int failures = 0;

  logic [5:0] shadow_m    = '0;
  logic [5:0] active_m    = '0;
  int         latch_total = 0;

  io_config_loader #(.NUM_IOB(NUM_IOB), .CFG_W(CFG_W)) dut (
    .IOCLK     (IOCLK),
    .RST_N     (RST_N),
    .START     (START),
    .ABORT     (ABORT),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .WDATA     (WDATA),
    .CFG_SDO   (CFG_SDO),
    .CFG_SEN   (CFG_SEN),
    .CFG_LATCH (CFG_LATCH),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 IOCLK = ~IOCLK;

  // Chain model: SDO enters block 0, block 0 feeds block 1; latch copies to active.
  always @(posedge IOCLK) begin
    if (CFG_SEN) shadow_m <= {shadow_m[4:0], CFG_SDO};
    if (CFG_LATCH) begin
      active_m    <= shadow_m;
      latch_total <= latch_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full load starting now (just after a falling edge); START cycle is cycle 1.
  task automatic run_load(input logic [2:0] w0, input logic [2:0] w1, input int gap,
                          input bit spam, input string tag);
    logic [2:0] words [2];
    logic [5:0] bits = '0;
    int nbits = 0, widx = 0, hold = 0, viol = 0;
    int latch_cyc = -1, done_cyc = -1, busy2 = 0, done_busy = 1;
    int latches0 = latch_total;
    bit pend = 1'b0;
    words[0] = w0;
    words[1] = w1;
    WDATA  = w0;
    WVALID = 1'b1;
    START  = 1'b1;
    for (int cyc = 2; cyc <= 60; cyc++) begin
      @(negedge IOCLK);
      START = spam && (cyc == 3 || cyc == 6 || cyc == 10);
      if (cyc == 2) busy2 = BUSY;
      if (CFG_SEN && CFG_LATCH) viol++;
      if (!CFG_SEN && CFG_SDO) viol++;
      if (CFG_SEN) begin
        bits = {bits[4:0], CFG_SDO};
        nbits++;
      end
      if (CFG_LATCH && latch_cyc < 0) latch_cyc = cyc;
      if (DONE && done_cyc < 0) begin
        done_cyc  = cyc;
        done_busy = BUSY;
      end
      if (pend) begin
        pend = 1'b0;
        widx++;
        if (widx < 2) WDATA = words[widx];
        if (widx == 1 && gap > 0) begin
          WVALID = 1'b0;
          hold   = gap;
        end
      end
      if (WREADY && WVALID) pend = 1'b1;
      else if (WREADY && !WVALID) begin
        if (hold > 0) hold--;
        else WVALID = 1'b1;
      end
      if (done_cyc > 0 && cyc == done_cyc + 2) break;
    end
    START  = 1'b0;
    WVALID = 1'b0;
    check({tag, "_bits"},      bits,                   {w0, w1});
    check({tag, "_nbits"},     nbits,                  6);
    check({tag, "_latch_cyc"}, latch_cyc,              10 + gap);
    check({tag, "_done_cyc"},  done_cyc,               11 + gap);
    check({tag, "_latches"},   latch_total - latches0, 1);
    check({tag, "_viol"},      viol,                   0);
    check({tag, "_busy2"},     busy2,                  1);
    check({tag, "_done_busy"}, done_busy,              0);
    check({tag, "_active"},    active_m,               {w0, w1});
    check({tag, "_idle"},      {WREADY, BUSY, DONE},   3'b001);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    logic [5:0] act0;

    // Power-on reset: outputs clear before any clock edge.
    #1 RST_N = 1'b0;
    #2;
    check("rst_async", {WREADY, CFG_SDO, CFG_SEN, CFG_LATCH, BUSY, DONE}, 6'b0);
    @(negedge IOCLK);
    @(negedge IOCLK);
    RST_N = 1'b1;
    @(negedge IOCLK);
    @(negedge IOCLK);
    check("rst_release", {WREADY, CFG_SDO, CFG_SEN, CFG_LATCH, BUSY, DONE}, 6'b0);

    run_load(3'b011, 3'b100, 0, 1'b0, "load1");
    run_load(3'b011, 3'b100, 5, 1'b0, "bp");

    // Abort on the second bit of the first word.
    act0   = active_m;
    l0     = latch_total;
    WDATA  = 3'b101;
    WVALID = 1'b1;
    START  = 1'b1;
    @(negedge IOCLK);
    START = 1'b0;
    check("ab_accept", WREADY, 1'b1);
    @(negedge IOCLK);
    check("ab_bit0", {CFG_SEN, CFG_SDO}, 2'b11);
    @(negedge IOCLK);
    check("ab_bit1", {CFG_SEN, CFG_SDO}, 2'b10);
    ABORT = 1'b1;
    @(negedge IOCLK);
    ABORT  = 1'b0;
    WVALID = 1'b0;
    check("ab_after", {BUSY, DONE, CFG_SEN, WREADY, CFG_LATCH}, 5'b0);
    repeat (5) @(negedge IOCLK);
    check("ab_nolatch", latch_total - l0, 0);
    check("ab_active", active_m, act0);

    // START wins over ABORT in IDLE; then ABORT beats a simultaneous transfer.
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge IOCLK);
    START = 1'b0;
    ABORT = 1'b0;
    check("sa_start_wins", {BUSY, WREADY}, 2'b11);
    @(negedge IOCLK);
    check("sa_hold_accept", {BUSY, WREADY, CFG_SEN}, 3'b110);
    WVALID = 1'b1;
    ABORT  = 1'b1;
    @(negedge IOCLK);
    ABORT  = 1'b0;
    WVALID = 1'b0;
    check("sa_abort_prio", {BUSY, WREADY, CFG_SEN}, 3'b000);
    @(negedge IOCLK);

    run_load(3'b110, 3'b001, 0, 1'b0, "load2");
    run_load(3'b101, 3'b010, 0, 1'b1, "spam");

    // Mid-cycle reset in IDLE clears sticky DONE without a clock edge.
    #2 RST_N = 1'b0;
    #1;
    check("rst_done_clr", {WREADY, CFG_SDO, CFG_SEN, CFG_LATCH, BUSY, DONE}, 6'b0);
    @(negedge IOCLK);
    RST_N = 1'b1;
    @(negedge IOCLK);
    @(negedge IOCLK);
    check("rst_stay0", {WREADY, BUSY, DONE}, 3'b0);

    // Reset during SHIFT.
    l0     = latch_total;
    WDATA  = 3'b111;
    WVALID = 1'b1;
    START  = 1'b1;
    @(negedge IOCLK);
    START = 1'b0;
    @(negedge IOCLK);
    check("rs_in_shift", {CFG_SEN, CFG_SDO, BUSY}, 3'b111);
    #2 RST_N = 1'b0;
    #1;
    check("rs_async", {WREADY, CFG_SDO, CFG_SEN, CFG_LATCH, BUSY, DONE}, 6'b0);
    WVALID = 1'b0;
    repeat (3) @(negedge IOCLK);
    RST_N = 1'b1;
    repeat (3) @(negedge IOCLK);
    check("rs_nolatch", latch_total - l0, 0);
    check("rs_active", active_m, 6'b101010);
    check("rs_idle", {WREADY, CFG_SEN, BUSY, DONE}, 4'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
